player_executor: RTL and testbench

Executes 16-bit player instructions from the game-state machine and owns the player's state inside the dodge box: position, HP, visibility, dodge enable and death. Sits between the state machine (instruction source, `isDeath` consumer) and the renderer (`posX`, `posY`, `isVisible`). Moves take one pixel per clock so the renderer sees smooth motion. Instruction format: [15:12] opcode, [11:4] argument, [3:0] reserved and ignored.

---
 rtl/player_executor_if.sv | 29 ++
 rtl/player_executor.sv | 209 ++++++++++++++++++++
 tb/tb_player_executor.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/player_executor_if.sv
// Player executor bus: instruction handshake from the game-state machine plus
// the player state published to the renderer and the state machine.
//   playerInstruction [15:0] : [15:12] opcode, [11:4] argument, [3:0] reserved
//   instrValid / instrReady  : instruction handshake
//   posX, posY [9:0]         : player position inside the dodge box
//   playerHP [7:0]           : current HP
//   isDeath, isDodging, isVisible : player status flags
// master = instruction source / state consumer, slave = player_executor.
interface player_executor_if;
  logic [15:0] playerInstruction;
  logic        instrValid;
  logic        instrReady;
  logic [9:0]  posX;
  logic [9:0]  posY;
  logic [7:0]  playerHP;
  logic        isDeath;
  logic        isDodging;
  logic        isVisible;

  modport master (
    output playerInstruction, instrValid,
    input  instrReady, posX, posY, playerHP, isDeath, isDodging, isVisible
  );

  modport slave (
    input  playerInstruction, instrValid,
    output instrReady, posX, posY, playerHP, isDeath, isDodging, isVisible
  );
endinterface

// File: rtl/player_executor.sv
// player_executor: executes 16-bit player instructions and owns the player's
// position, HP, visibility, dodge enable and death flag. MOV walks one pixel
// per clock so the renderer sees smooth motion.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : player_executor_if.slave (instruction handshake + player state)
// Optional feature: define PLAYER_IFRAME_EN to add an invulnerability window
// of IFRAMES cycles after each damaging DPY.
//
// state | meaning
// IDLE  | ready for any instruction
// MOVE  | walking STEP pixels, instructions held off
// DEAD  | HP is 0, only HPY with a nonzero argument revives
module player_executor #(
  parameter int BOX_W   = 200,
  parameter int BOX_H   = 140,
  parameter int STEP    = 4,
  parameter int MAX_HP  = 100,
  parameter int IFRAMES = 60
) (
  input logic               clk,
  input logic               reset,
  player_executor_if.slave  bus
);
  localparam int          CW     = $clog2(STEP + 1);
  localparam logic [9:0]  X_MAX  = 10'(BOX_W - 1);
  localparam logic [9:0]  Y_MAX  = 10'(BOX_H - 1);
  localparam logic [9:0]  X_MID  = 10'(BOX_W / 2);
  localparam logic [9:0]  Y_MID  = 10'(BOX_H / 2);
  localparam logic [7:0]  HP_MAX = 8'(MAX_HP);

  localparam logic [3:0] OP_HPY = 4'd1;
  localparam logic [3:0] OP_DPY = 4'd2;
  localparam logic [3:0] OP_IDG = 4'd3;
  localparam logic [3:0] OP_SDG = 4'd4;
  localparam logic [3:0] OP_MOV = 4'd5;
  localparam logic [3:0] OP_SHP = 4'd6;

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DEAD} state_t;

  state_t        state_q, state_d;
  logic [9:0]    pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [7:0]    hp_q, hp_d;
  logic          death_q, death_d, dodge_q, dodge_d, vis_q, vis_d;
  logic [1:0]    dir_q, dir_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic       accept, blocked, dpy_ok;
  logic [3:0] op;
  logic [7:0] arg, hpy_val, dmg_val;
  logic       unused_rsvd;

  assign op          = bus.playerInstruction[15:12];
  assign arg         = bus.playerInstruction[11:4];
  assign unused_rsvd = ^bus.playerInstruction[3:0];
  assign accept      = bus.instrValid && (state_q != S_MOVE);
  assign hpy_val     = (arg > HP_MAX) ? HP_MAX : arg;
  assign dmg_val     = (arg >= hp_q) ? 8'd0 : hp_q - arg;

`ifdef PLAYER_IFRAME_EN
  localparam int IFW = $clog2(IFRAMES + 1);
  logic [IFW-1:0] ifr_q, ifr_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ifr_q <= '0;
    else       ifr_q <= ifr_d;
  end
`endif

  // The next pixel in the current direction would leave the box.
  always_comb begin
    blocked = 1'b0;
    case (dir_q)
      2'd0:    blocked = (pos_y_q == 10'd0);
      2'd1:    blocked = (pos_x_q == 10'd0);
      2'd2:    blocked = (pos_y_q == Y_MAX);
      default: blocked = (pos_x_q == X_MAX);
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pos_x_q <= X_MID;
      pos_y_q <= Y_MID;
      hp_q    <= HP_MAX;
      death_q <= 1'b0;
      dodge_q <= 1'b0;
      vis_q   <= 1'b0;
      dir_q   <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      hp_q    <= hp_d;
      death_q <= death_d;
      dodge_q <= dodge_d;
      vis_q   <= vis_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    hp_d    = hp_q;
    death_d = death_q;
    dodge_d = dodge_q;
    vis_d   = vis_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
`ifdef PLAYER_IFRAME_EN
    ifr_d   = (ifr_q != '0) ? ifr_q - 1'b1 : ifr_q;
    dpy_ok  = (ifr_q == '0);
`else
    dpy_ok  = 1'b1;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (op)
            OP_HPY: begin
              hp_d = hpy_val;
`ifdef PLAYER_IFRAME_EN
              ifr_d = '0;
`endif
              if (hpy_val == 8'd0) begin
                state_d = S_DEAD;
                death_d = 1'b1;
                dodge_d = 1'b0;
              end
            end
            OP_DPY: begin
              if (arg != 8'd0 && dpy_ok) begin
                hp_d = dmg_val;
`ifdef PLAYER_IFRAME_EN
                ifr_d = IFW'(IFRAMES);
`endif
                if (dmg_val == 8'd0) begin
                  state_d = S_DEAD;
                  death_d = 1'b1;
                  dodge_d = 1'b0;
                end
              end
            end
            OP_IDG: begin
              pos_x_d = X_MID;
              pos_y_d = Y_MID;
              dodge_d = 1'b1;
`ifdef PLAYER_IFRAME_EN
              ifr_d = '0;
`endif
            end
            OP_SDG: dodge_d = 1'b0;
            OP_MOV: begin
              // With dodging off the MOV is swallowed as a no-op.
              if (dodge_q) begin
                dir_d   = arg[1:0];
                cnt_d   = CW'(STEP);
                state_d = S_MOVE;
              end
            end
            OP_SHP: vis_d = arg[0];
            default: ;
          endcase
        end
      end
      S_MOVE: begin
        if (blocked) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          case (dir_q)
            2'd0:    pos_y_d = pos_y_q - 10'd1;
            2'd1:    pos_x_d = pos_x_q - 10'd1;
            2'd2:    pos_y_d = pos_y_q + 10'd1;
            default: pos_x_d = pos_x_q + 10'd1;
          endcase
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_d = S_IDLE;
        end
      end
      default: begin
        if (accept && op == OP_HPY) begin
`ifdef PLAYER_IFRAME_EN
          ifr_d = '0;
`endif
          if (hpy_val != 8'd0) begin
            hp_d    = hpy_val;
            death_d = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
    endcase
  end

  assign bus.instrReady = (state_q != S_MOVE);
  assign bus.posX       = pos_x_q;
  assign bus.posY       = pos_y_q;
  assign bus.playerHP   = hp_q;
  assign bus.isDeath    = death_q;
  assign bus.isDodging  = dodge_q;
  assign bus.isVisible  = vis_q;
endmodule

// File: tb/tb_player_executor.sv
module tb_player_executor;
  localparam int BOX_W   = 200;
  localparam int BOX_H   = 140;
  localparam int STEP    = 4;
  localparam int MAX_HP  = 100;
  localparam int IFRAMES = 60;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  player_executor_if bus();

  player_executor #(
    .BOX_W(BOX_W), .BOX_H(BOX_H), .STEP(STEP), .MAX_HP(MAX_HP), .IFRAMES(IFRAMES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] hp;
    logic       death;
    logic       dodge;
    logic       vis;
    logic       ready;
  } snap_t;

  snap_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model of the player: plain integers, one instruction at a time.
  int mx, my, mhp;
  bit mdeath, mdodge, mvis;
  bit hit_valid;
  int hit_cyc;

  function automatic snap_t cur(bit r);
    snap_t s;
    s.x = mx[9:0]; s.y = my[9:0]; s.hp = mhp[7:0];
    s.death = mdeath; s.dodge = mdodge; s.vis = mvis; s.ready = r;
    return s;
  endfunction

  function automatic snap_t dut_snap();
    snap_t s;
    s.x = bus.posX; s.y = bus.posY; s.hp = bus.playerHP;
    s.death = bus.isDeath; s.dodge = bus.isDodging; s.vis = bus.isVisible;
    s.ready = bus.instrReady;
    return s;
  endfunction

  function automatic bit iframe_block(int acc);
`ifdef PLAYER_IFRAME_EN
    return hit_valid && ((acc - hit_cyc) <= IFRAMES);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    mx = BOX_W / 2; my = BOX_H / 2; mhp = MAX_HP;
    mdeath = 0; mdodge = 0; mvis = 0; hit_valid = 0; hit_cyc = 0;
  endtask

  task automatic chk(string nm, snap_t a, snap_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s t=%0t got x=%0d y=%0d hp=%0d death=%b dodge=%b vis=%b rdy=%b want x=%0d y=%0d hp=%0d death=%b dodge=%b vis=%b rdy=%b",
               nm, $time, a.x, a.y, a.hp, a.death, a.dodge, a.vis, a.ready,
               e.x, e.y, e.hp, e.death, e.dodge, e.vis, e.ready);
    end
  endtask

  // Monitor: one expected snapshot per clock while the scoreboard is non-empty.
  initial begin
    snap_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("snap", dut_snap(), e);
      end
    end
  end

  // Called at a negedge; drives one instruction, queues the expected state for
  // every cycle until the block is ready again, and returns at a negedge.
  task automatic issue(int op, int arg);
    snap_t s[$];
    int acc, room, m;
    bit pushed;
    acc = cyc + 1;
    pushed = 0;
    bus.playerInstruction = {op[3:0], arg[7:0], 4'($urandom)};
    bus.instrValid = 1'b1;
    if (mdeath) begin
      if (op == 1) begin
        hit_valid = 0;
        if (arg > 0) begin
          mhp = (arg > MAX_HP) ? MAX_HP : arg;
          mdeath = 0;
        end
      end
    end else begin
      case (op)
        1: begin
          mhp = (arg > MAX_HP) ? MAX_HP : arg;
          hit_valid = 0;
          if (mhp == 0) begin mdeath = 1; mdodge = 0; end
        end
        2: begin
          if (arg != 0 && !iframe_block(acc)) begin
            mhp = (mhp > arg) ? mhp - arg : 0;
            hit_valid = 1; hit_cyc = acc;
            if (mhp == 0) begin mdeath = 1; mdodge = 0; end
          end
        end
        3: begin mx = BOX_W / 2; my = BOX_H / 2; mdodge = 1; hit_valid = 0; end
        4: mdodge = 0;
        5: begin
          if (mdodge) begin
            case (arg % 4)
              0: room = my;
              1: room = mx;
              2: room = BOX_H - 1 - my;
              default: room = BOX_W - 1 - mx;
            endcase
            m = (room < STEP) ? room : STEP;
            s.push_back(cur(0));
            for (int j = 1; j <= m; j++) begin
              case (arg % 4)
                0: my--;
                1: mx--;
                2: my++;
                default: mx++;
              endcase
              s.push_back(cur(j == STEP));
            end
            if (m < STEP) s.push_back(cur(1));
            pushed = 1;
          end
        end
        6: mvis = arg[0];
        default: ;
      endcase
    end
    if (!pushed) s.push_back(cur(1));
    foreach (s[i]) exp_q.push_back(s[i]);
    @(posedge clk);
    @(negedge clk);
    bus.instrValid = 1'b0;
    if (s.size() > 1) begin
      repeat (s.size() - 1) @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic idle(int n);
    repeat (n) begin
      exp_q.push_back(cur(1));
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    int pick, op, arg;
    reset = 1'b1;
    bus.instrValid = 1'b0;
    bus.playerInstruction = 16'h0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset_state", dut_snap(), cur(1));

    // Centre, show, then walk right.
    issue(3, 0);
    issue(6, 1);
    issue(5, 3);

    // Walk up into the top wall; the last MOV starts at y=0.
    issue(3, 0);
    repeat (19) issue(5, 0);

    // Death and revival.
    issue(1, 30);
    issue(2, 50);
    issue(5, 3);
    issue(6, 0);
    issue(1, 0);
    issue(1, 20);
    issue(1, 0);
    issue(1, 250);

    // Damage spacing around the invulnerability window.
    issue(1, 100);
    issue(2, 10);
    idle(1);
    issue(2, 10);
    idle(58);
    issue(2, 10);
    issue(2, 0);

    // Asynchronous reset in the middle of a move.
    issue(3, 0);
    bus.playerInstruction = {4'd5, 8'd3, 4'd0};
    bus.instrValid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.instrValid = 1'b0;
    @(posedge clk);
    #3 reset = 1'b1;
    model_reset();
    #1 chk("async_reset", dut_snap(), cur(1));
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1 chk("after_reset", dut_snap(), cur(1));
    @(negedge clk);

    // Randomised traffic.
    issue(3, 0);
    repeat (400) begin
      pick = $urandom_range(0, 19);
      arg = $urandom_range(0, 255);
      if (pick == 0) begin
        idle($urandom_range(1, 3));
      end else begin
        if (pick <= 2)       begin op = 1; arg = $urandom_range(0, 130); end
        else if (pick <= 5)  begin op = 2; arg = $urandom_range(0, 40); end
        else if (pick == 6)  op = 3;
        else if (pick == 7)  op = 4;
        else if (pick <= 14) op = 5;
        else if (pick <= 16) op = 6;
        else begin
          op = $urandom_range(7, 16);
          if (op == 16) op = 0;
        end
        issue(op, arg);
      end
    end

    idle(2);
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
